// File: rtl/regfile_mp.sv
// Multi-ported register file: two combinational read ports, two write ports and a
// per-register pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_v,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // NOTE: the whole array is cleared asynchronously, so it maps to flops rather than a RAM macro;
  // a RAM cannot be cleared in zero time.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments in source order: the later port-1 write overrides port 0 on a collision.
      if (we0 && wa0 != '0) regs[wa0] <= wd0;
      if (we1 && wa1 != '0) regs[wa1] <= wd1;
    end
  end

  // Writebacks clear first, then an issue to the same register sets the bit again.
  always_comb begin
    // NOTE: default assignment first, so every path assigns busy_nxt and no latch is inferred.
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (iss_v && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_comb begin
    qa     = regs[ra_a];
    qb     = regs[ra_b];
    busy_a = busy[ra_a];
    busy_b = busy[ra_b];
`ifdef REGFILE_BYPASS_EN
    // Port 1 is checked last so it takes precedence, matching the write collision rule.
    if (we0 && wa0 != '0 && wa0 == ra_a) begin qa = wd0; busy_a = 1'b0; end
    if (we1 && wa1 != '0 && wa1 == ra_a) begin qa = wd1; busy_a = 1'b0; end
    if (we0 && wa0 != '0 && wa0 == ra_b) begin qb = wd0; busy_b = 1'b0; end
    if (we1 && wa1 != '0 && wa1 == ra_b) begin qb = wd1; busy_b = 1'b0; end
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, corner sequences,
// randomized traffic against an array model, and a narrow-parameter instance.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  ra_a, ra_b, wa0, wa1, iss_rd;
  logic [31:0] qa, qb, wd0, wd1;
  logic        we0, we1, iss_v, busy_a, busy_b;

  logic [2:0]  p_ra_a, p_ra_b, p_wa0, p_wa1, p_iss_rd;
  logic [15:0] p_qa, p_qb, p_wd0, p_wd1;
  logic        p_we0, p_we1, p_iss_v, p_busy_a, p_busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .clrn(clrn), .ra_a(ra_a), .ra_b(ra_b), .qa(qa), .qb(qb),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_v(iss_v), .iss_rd(iss_rd), .busy_a(busy_a), .busy_b(busy_b)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3)) dut_p (
    .clk(clk), .clrn(clrn), .ra_a(p_ra_a), .ra_b(p_ra_b), .qa(p_qa), .qb(p_qb),
    .we0(p_we0), .we1(p_we1), .wa0(p_wa0), .wa1(p_wa1), .wd0(p_wd0), .wd1(p_wd1),
    .iss_v(p_iss_v), .iss_rd(p_iss_rd), .busy_a(p_busy_a), .busy_b(p_busy_b)
  );

  typedef struct {
    logic        we0;  logic [4:0] wa0; logic [31:0] wd0;
    logic        we1;  logic [4:0] wa1; logic [31:0] wd1;
    logic        iss_v; logic [4:0] iss_rd;
    logic [4:0]  ra_a; logic [4:0] ra_b;
    logic [31:0] exp_qa; logic [31:0] exp_qb;
    logic        exp_ba; logic        exp_bb;
  } vec_t;

  // Reference model: plain arrays updated by the architectural rules.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
  endtask

  function automatic logic [31:0] model_q(input vec_t v, input logic [4:0] ra);
    logic [31:0] q;
    q = m_regs[ra];
`ifdef REGFILE_BYPASS_EN
    if (v.we1 && v.wa1 != 0 && v.wa1 == ra) q = v.wd1;
    else if (v.we0 && v.wa0 != 0 && v.wa0 == ra) q = v.wd0;
`endif
    return q;
  endfunction

  function automatic logic model_busy(input vec_t v, input logic [4:0] ra);
    logic b;
    b = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
    if ((v.we1 && v.wa1 != 0 && v.wa1 == ra) || (v.we0 && v.wa0 != 0 && v.wa0 == ra)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic model_clock(input vec_t v);
    if (v.we0 && v.wa0 != 0) m_regs[v.wa0] = v.wd0;
    if (v.we1 && v.wa1 != 0) m_regs[v.wa1] = v.wd1;
    if (v.we0) m_busy[v.wa0] = 1'b0;
    if (v.we1) m_busy[v.wa1] = 1'b0;
    if (v.iss_v && v.iss_rd != 0) m_busy[v.iss_rd] = 1'b1;
  endtask

  task automatic set_idle();
    we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_v = 0; iss_rd = 0;
  endtask

  // Called at posedge+1: drive, sample at the falling edge, then clock the model.
  task automatic apply(input vec_t v, input string tag);
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    iss_v = v.iss_v; iss_rd = v.iss_rd; ra_a = v.ra_a; ra_b = v.ra_b;
    #4;
    check({tag, ".qa"}, qa, v.exp_qa);
    check({tag, ".qb"}, qb, v.exp_qb);
    check({tag, ".busy_a"}, {31'b0, busy_a}, {31'b0, v.exp_ba});
    check({tag, ".busy_b"}, {31'b0, busy_b}, {31'b0, v.exp_bb});
    @(posedge clk);
    model_clock(v);
    #1;
  endtask

  function automatic vec_t mk(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic iv, input logic [4:0] ir,
                              input logic [4:0] rA, input logic [4:0] rB,
                              input logic [31:0] eqa, input logic [31:0] eqb,
                              input logic eba, input logic ebb);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.iss_v = iv; v.iss_rd = ir; v.ra_a = rA; v.ra_b = rB;
    v.exp_qa = eqa; v.exp_qb = eqb; v.exp_ba = eba; v.exp_bb = ebb;
    return v;
  endfunction

  vec_t tbl [10];
  vec_t v;

  initial begin
    clrn = 1'b0;
    set_idle();
    ra_a = 5'd3; ra_b = 5'd7;
    p_we0 = 0; p_we1 = 0; p_wa0 = 0; p_wa1 = 0; p_wd0 = 0; p_wd1 = 0;
    p_iss_v = 0; p_iss_rd = 0; p_ra_a = 0; p_ra_b = 0;
    model_reset();
    #2;
    check("reset.qa", qa, 32'h0);
    check("reset.busy_a", {31'b0, busy_a}, 32'h0);
    #10 clrn = 1'b1;
    @(posedge clk); #1;

    // Directed table; reads never hit a same-cycle write, so values hold with or without bypass.
    tbl[0] = mk(1, 3, 32'h30000033, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 1, 5, 3, 4, 32'h30000033, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 3, 0, 32'h30000033, 1, 0);
    tbl[3] = mk(0, 0, 0, 1, 5, 32'h55, 0, 0, 3, 6, 32'h30000033, 0, 0, 0);
    tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 32'h55, 0, 0, 0);
    tbl[5] = mk(1, 5, 32'h5a, 0, 0, 0, 1, 5, 3, 4, 32'h30000033, 0, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 32'h5a, 0, 1, 0);
    tbl[7] = mk(1, 7, 32'h11111111, 1, 7, 32'h77777777, 0, 0, 5, 3, 32'h5a, 32'h30000033, 1, 0);
    tbl[8] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 7, 5, 32'h77777777, 32'h5a, 0, 1);
    tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Same-cycle write to reg9 read on port B, then the stored value.
`ifdef REGFILE_BYPASS_EN
    apply(mk(1, 9, 32'h90000099, 0, 0, 0, 0, 0, 0, 9, 0, 32'h90000099, 0, 0), "bypass.same");
`else
    apply(mk(1, 9, 32'h90000099, 0, 0, 0, 0, 0, 0, 9, 0, 32'h0, 0, 0), "bypass.same");
`endif
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h90000099, 32'h90000099, 0, 0), "bypass.next");

    // Randomized traffic, addresses biased low so hits and collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      v.we0 = 1'($urandom_range(0, 1)); v.wa0 = 5'($urandom_range(0, 11)); v.wd0 = $urandom;
      v.we1 = 1'($urandom_range(0, 1)); v.wa1 = 5'($urandom_range(0, 11)); v.wd1 = $urandom;
      v.iss_v = 1'($urandom_range(0, 1)); v.iss_rd = 5'($urandom_range(0, 11));
      v.ra_a = (n % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
      v.ra_b = 5'($urandom_range(0, 11));
      v.exp_qa = model_q(v, v.ra_a); v.exp_qb = model_q(v, v.ra_b);
      v.exp_ba = model_busy(v, v.ra_a); v.exp_bb = model_busy(v, v.ra_b);
      apply(v, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-run: reg3 written and busy, then clrn drops between edges.
    apply(mk(1, 3, 32'h30000033, 0, 0, 0, 1, 3, 3, 3, model_q(mk(1,3,32'h30000033,0,0,0,1,3,3,3,0,0,0,0), 3),
             model_q(mk(1,3,32'h30000033,0,0,0,1,3,3,3,0,0,0,0), 3),
             model_busy(mk(1,3,32'h30000033,0,0,0,1,3,3,3,0,0,0,0), 3),
             model_busy(mk(1,3,32'h30000033,0,0,0,1,3,3,3,0,0,0,0), 3)), "pre_rst");
    set_idle(); ra_a = 5'd3; ra_b = 5'd3;
    #1;
    check("pre_rst.qa3", qa, 32'h30000033);
    check("pre_rst.busy3", {31'b0, busy_a}, 32'h1);
    clrn = 1'b0;
    #1;
    check("rst_async.qa3", qa, 32'h0);
    check("rst_async.busy3", {31'b0, busy_a}, 32'h0);
    we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; we1 = 1; wa1 = 4; wd1 = 32'hCAFEF00D; iss_v = 1; iss_rd = 6;
    @(posedge clk); #1;
    ra_b = 5'd4;
    #1;
    check("rst_hold.qa3", qa, 32'h0);
    check("rst_hold.qb4", qb, 32'h0);
    set_idle();
    #2 clrn = 1'b1;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      ra_a = 5'(a); ra_b = 5'(31 - a);
      #1;
      check($sformatf("post_rst.qa%0d", a), qa, 32'h0);
      check($sformatf("post_rst.busy_a%0d", a), {31'b0, busy_a}, 32'h0);
      check($sformatf("post_rst.busy_b%0d", 31 - a), {31'b0, busy_b}, 32'h0);
    end
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 1, 6, 6, 4, 0, 0, 0, 0), "post_rst.iss6");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 3, 0, 0, 1, 0), "post_rst.busy6");

    // Narrow instance: 16-bit data, 8 registers; reg7 is the top address.
    p_we0 = 1; p_wa0 = 3'd7; p_wd0 = 16'hABCD;
    p_we1 = 1; p_wa1 = 3'd6; p_wd1 = 16'h1234;
    p_iss_v = 1; p_iss_rd = 3'd7; p_ra_a = 3'd7; p_ra_b = 3'd6;
    @(posedge clk); #1;
    p_we0 = 0; p_we1 = 0; p_iss_v = 0;
    #1;
    check("p16.qa7", {16'b0, p_qa}, 32'h0000ABCD);
    check("p16.qb6", {16'b0, p_qb}, 32'h00001234);
    check("p16.busy7", {31'b0, p_busy_a}, 32'h1);
    p_ra_a = 3'd0;
    #1;
    check("p16.qa0", {16'b0, p_qa}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ra_a, ra_b  input  ADDR_W  read addresses, ports A and B.
REQ-006 SHALL have ports qa, qb  output  DATA_W  read data, ports A and B.
REQ-007 SHALL have ports we0, we1  input  1  write enables, write ports 0 (ALU) and 1 (load).
REQ-008 SHALL have ports wa0, wa1  input  ADDR_W  write addresses.
REQ-009 SHALL have ports wd0, wd1  input  DATA_W  write data.
REQ-010 SHALL have port iss_v  input  1  issue strobe; marks iss_rd as pending write.
REQ-011 SHALL have port iss_rd  input  ADDR_W  destination register being issued.
REQ-012 SHALL have ports busy_a, busy_b  output  1  pending-write flag for ra_a / ra_b.

Function
REQ-013 SHALL hold 2**ADDR_W registers of DATA_W bits; register 0 reads as 0 and ignores writes.
REQ-014 SHALL read combinationally: qa = reg[ra_a], qb = reg[ra_b], zero latency.
REQ-015 SHALL write wd0 to reg[wa0] at rising clk when we0=1 and wa0!=0; likewise port 1.
REQ-016 SHALL, when both ports write the same nonzero address in one cycle, store wd1 (port 1 wins).
REQ-017 SHALL keep a busy bit per register; reg 0 busy bit is constant 0.
REQ-018 SHALL set busy[iss_rd] at rising clk when iss_v=1 and iss_rd!=0.
REQ-019 SHALL clear busy[wa0] when we0=1 and busy[wa1] when we1=1, at rising clk.
REQ-020 SHALL, when issue and a writeback target the same register in one cycle, leave busy set (issue wins).
REQ-021 SHALL drive busy_a = busy[ra_a], busy_b = busy[ra_b] combinationally, after any write clear is applied only from the next cycle.
REQ-022 SHALL accept any combination of simultaneous issue, two writes and two reads every cycle; no stall outputs.

Reset
REQ-023 SHALL, while clrn=0, force all registers to 0 and all busy bits to 0 immediately, independent of clk.
REQ-024 SHALL drop writes and issues presented while clrn=0; first update occurs at the first rising clk with clrn=1.
REQ-025 SHALL, after reset, read qa=qb=0 and busy_a=busy_b=0 for every address.

Configuration
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, return same-cycle write data on a read whose address matches an enabled nonzero write (port 1 over port 0), and force busy_x=0 for that read.
REQ-027 SHALL, with REGFILE_BYPASS_EN undefined, return the stored value; new data visible the cycle after the write edge.

Verification
REQ-028 SHALL verify reset: clrn=0 mid-run after writing reg3=32'h30000033 -> qa(ra_a=3)=0, busy_a=0 immediately, before any clk edge.
REQ-029 SHALL verify dual-write collision: we0=we1=1, wa0=wa1=7, wd0=32'h11111111, wd1=32'h77777777 -> next cycle qa(7)=32'h77777777.
REQ-030 SHALL verify reg 0: we0=1, wa0=0, wd0=32'hFFFFFFFF; iss_v=1, iss_rd=0 -> qa(0)=0, busy_a(0)=0 forever.
REQ-031 SHALL verify scoreboard: iss_v, iss_rd=5 -> busy_a(5)=1 next cycle; we1, wa1=5 -> busy_a(5)=0 following cycle; iss_rd=5 with we0, wa0=5 same cycle -> busy stays 1.
REQ-032 SHALL verify bypass: reg9=0, we0=1, wa0=9, wd0=32'h90000099, ra_b=9 same cycle -> qb=32'h90000099 with REGFILE_BYPASS_EN, qb=0 without; both read 32'h90000099 next cycle.
REQ-033 SHALL verify parameters: DATA_W=16, ADDR_W=3 -> write reg7=16'hABCD, read back 16'hABCD; address 7 is the highest valid register.
